event_loop_seq: RTL and testbench
=================================

# event_loop_seq

Multi-channel event-triggered loop sequencer. Each of `NCH` independent channels is armed, waits for a qualifying event on its input, then issues a programmable number of step requests over a valid/ready handshake. The loop has do-while semantics: at least one step per trigger. It reports completion, and optionally re-arms itself indefinitely. It sits between synchronous event sources (status flags, strobes) and downstream engines that consume one step per handshake.

## Interface
Parameters:
- `NCH`, 4, number of channels (1..16)
- `CNT_W`, 8, width of per-channel iteration count

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ev`  in  NCH  per-channel event inputs, synchronous to `clk`
- `edge_mode`  in  2*NCH  per channel: 00 rise, 01 fall, 10 any edge, 11 level-high
- `repeat_en`  in  NCH  1 = re-arm after DONE (forever mode), 0 = return to IDLE
- `count`  in  NCH*CNT_W  iterations per trigger; 0 treated as 1
- `arm`  in  NCH  arm request, sampled in IDLE only
- `abort`  in  NCH  force channel to IDLE
- `step_ready`  in  NCH  downstream accepts step
- `step_valid`  out  NCH  step request
- `done`  out  NCH  one-cycle pulse after last step accepted
- `busy`  out  NCH  channel not IDLE
- `overrun`  out  NCH  sticky: event while channel in RUN or DONE
- `clr_ovr`  in  NCH  clear `overrun`

## Operation
- Per-channel FSM with states IDLE, ARMED, RUN and DONE:
  - IDLE -> ARMED when `arm[i]`=1.
  - ARMED -> RUN on a qualifying event. At the same edge, `rem[i]` latches max(`count[i]`,1).
  - RUN: `step_valid[i]`=1. Each edge with `step_valid`&`step_ready` decrements `rem`. The handshake with `rem`=1 moves the channel to DONE.
  - DONE -> ARMED if `repeat_en[i]`, else IDLE. DONE always lasts one cycle.
- Event qualification uses `ev_q`, a one-cycle registered copy of `ev`, which updates every cycle in every state:
  - rise: `ev`&~`ev_q`
  - fall: ~`ev`&`ev_q`
  - any: `ev`^`ev_q`
  - level: `ev`
- `edge_mode` and `repeat_en` are sampled live. `count` is sampled only on the ARMED->RUN edge.
- Priority:
  - `abort` beats all other inputs and takes any state to IDLE next edge. It drops `step_valid` and suppresses `done`.
  - `arm` outside IDLE is ignored.
- `overrun[i]` sets on any qualifying event while in RUN or DONE. Such events are never queued. When set and `clr_ovr` occur in the same cycle, set wins.
- `busy[i]` = (state != IDLE).
- `done[i]` = (state == DONE).
- `step_valid[i]` = (state == RUN).
- Channels are fully independent; there is no shared arbitration.

## Timing
- Reset values: all FSMs IDLE; `ev_q`=0; `rem`=0; `step_valid`, `done`, `busy`, `overrun` all 0.
- Assertion of `rst_n` low mid-operation aborts every channel immediately. No `done` is generated.
- `arm` at edge k: `busy`=1 after k.
- Qualifying event sampled at edge m: `step_valid`=1 after m. Event-to-valid latency is 1 cycle.
- `step_valid` is held until accepted and never drops without handshake, except on `abort`.
- Step throughput is one per cycle with `step_ready` tied high. N iterations occupy exactly N cycles in RUN, followed by 1 DONE cycle.
- Re-arm latency: the earliest new trigger is captured at the edge ending the DONE cycle+1, i.e. the first ARMED cycle.
- A `count` change during RUN has no effect on the current loop.
- `ev_q`=0 at reset: `ev` high at reset release counts as a rise, but is only acted on if the channel is already ARMED.

## Test plan
- Basic loop: ch0 rise mode, `count`=3, `step_ready`=1, arm, then pulse `ev` -> `step_valid` high exactly 3 cycles starting 1 cycle after the event edge, then `done` for 1 cycle, `busy`=0 afterwards.
- Do-while and backpressure: `count`=0, `step_ready` low for 4 cycles then high -> one step, `step_valid` held 5 cycles, a single `done`.
- Forever and overrun: `repeat_en`=1, `count`=2, events every 2 cycles -> sequence re-arms after each DONE; events landing in RUN or DONE set `overrun`. `clr_ovr` coinciding with a new overrun leaves `overrun`=1.
- Edge modes: drive `ev` pattern 0,1,1,0 on 4 channels configured rise/fall/any/level -> triggers at the 1st, 3rd, 1st and 1st transition respectively. The level channel re-triggers while high after re-arm in repeat mode.
- Abort and reset: abort in RUN with `rem`=2 -> IDLE next cycle, no `done`. Assert `rst_n`=0 mid-RUN asynchronously -> all outputs 0 immediately, then clean re-arm after release.
- Independence: all `NCH` channels triggered in the same cycle with different `count` values (1, 4, 7, 255) -> each completes with the correct step count; the 255-step channel ends after 255+1 cycles.

Source files
------------

// File: rtl/event_loop_seq.sv
// Multi-channel event-triggered loop sequencer: each channel waits for a qualified
// event, then issues max(count,1) handshaked steps, pulses done and optionally re-arms.
module event_loop_seq #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       ev,
    input  logic [2*NCH-1:0]     edge_mode,
    input  logic [NCH-1:0]       repeat_en,
    input  logic [NCH*CNT_W-1:0] count,
    input  logic [NCH-1:0]       arm,
    input  logic [NCH-1:0]       abort,
    input  logic [NCH-1:0]       step_ready,
    output logic [NCH-1:0]       step_valid,
    output logic [NCH-1:0]       done,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       overrun,
    input  logic [NCH-1:0]       clr_ovr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    logic [NCH-1:0] ev_q;

    // Previous-cycle event copy shared by every channel's edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_q <= '0;
        end else begin
            ev_q <= ev;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] rem;
        logic [CNT_W-1:0] rem_nxt;
        logic [CNT_W-1:0] cnt_load;
        logic             qual;
        logic             sv_r;
        logic             done_r;
        logic             busy_r;
        logic             ovr_r;

        always_comb begin
            case (edge_mode[2*i +: 2])
                2'b00:   qual = ev[i] & ~ev_q[i];
                2'b01:   qual = ~ev[i] & ev_q[i];
                2'b10:   qual = ev[i] ^ ev_q[i];
                default: qual = ev[i];
            endcase
        end

        // A zero count still runs one step: the loop is do-while.
        assign cnt_load = (count[i*CNT_W +: CNT_W] == '0) ? CNT_W'(1)
                                                          : count[i*CNT_W +: CNT_W];

        always_comb begin
            state_nxt = state;
            rem_nxt   = rem;
            if (abort[i]) begin
                state_nxt = S_IDLE;
                rem_nxt   = '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (arm[i]) state_nxt = S_ARMED;
                    end
                    S_ARMED: begin
                        if (qual) begin
                            state_nxt = S_RUN;
                            rem_nxt   = cnt_load;
                        end
                    end
                    S_RUN: begin
                        if (step_ready[i]) begin
                            rem_nxt = rem - CNT_W'(1);
                            if (rem == CNT_W'(1)) state_nxt = S_DONE;
                        end
                    end
                    default: begin
                        state_nxt = repeat_en[i] ? S_ARMED : S_IDLE;
                    end
                endcase
            end
        end

        // Outputs are registered from the next state so they line up with the FSM.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state  <= S_IDLE;
                rem    <= '0;
                sv_r   <= 1'b0;
                done_r <= 1'b0;
                busy_r <= 1'b0;
                ovr_r  <= 1'b0;
            end else begin
                state  <= state_nxt;
                rem    <= rem_nxt;
                sv_r   <= (state_nxt == S_RUN);
                done_r <= (state_nxt == S_DONE);
                busy_r <= (state_nxt != S_IDLE);
                if ((state == S_RUN || state == S_DONE) && qual) begin
                    ovr_r <= 1'b1;
                end else if (clr_ovr[i]) begin
                    ovr_r <= 1'b0;
                end
            end
        end

        assign step_valid[i] = sv_r;
        assign done[i]       = done_r;
        assign busy[i]       = busy_r;
        assign overrun[i]    = ovr_r;
    end

endmodule

// File: tb/tb_event_loop_seq.sv
// Self-checking bench for event_loop_seq: directed scenarios with literal checks
// plus a per-cycle comparison against a behavioural channel model.
module tb_event_loop_seq;

    localparam int NCH   = 4;
    localparam int CNT_W = 8;

    logic                 clk;
    logic                 rst_n;
    logic [NCH-1:0]       ev;
    logic [2*NCH-1:0]     edge_mode;
    logic [NCH-1:0]       repeat_en;
    logic [NCH*CNT_W-1:0] count;
    logic [NCH-1:0]       arm;
    logic [NCH-1:0]       abort;
    logic [NCH-1:0]       step_ready;
    logic [NCH-1:0]       step_valid;
    logic [NCH-1:0]       done;
    logic [NCH-1:0]       busy;
    logic [NCH-1:0]       overrun;
    logic [NCH-1:0]       clr_ovr;

    int errors = 0;
    int checks = 0;
    bit check_en = 0;

    event_loop_seq #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ev         (ev),
        .edge_mode  (edge_mode),
        .repeat_en  (repeat_en),
        .count      (count),
        .arm        (arm),
        .abort      (abort),
        .step_ready (step_ready),
        .step_valid (step_valid),
        .done       (done),
        .busy       (busy),
        .overrun    (overrun),
        .clr_ovr    (clr_ovr)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: armed flag, steps still owed, pending done pulse.
    bit m_armed [NCH];
    int m_left  [NCH];
    bit m_done  [NCH];
    bit m_ovr   [NCH];
    bit m_evq   [NCH];

    always @(posedge clk or negedge rst_n) begin : model
        bit q;
        int c;
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                m_armed[i] <= 0;
                m_left[i]  <= 0;
                m_done[i]  <= 0;
                m_ovr[i]   <= 0;
                m_evq[i]   <= 0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                case (edge_mode[2*i +: 2])
                    2'b00:   q = ev[i] && !m_evq[i];
                    2'b01:   q = !ev[i] && m_evq[i];
                    2'b10:   q = ev[i] != m_evq[i];
                    default: q = ev[i];
                endcase
                c = int'(count[i*CNT_W +: CNT_W]);
                m_evq[i] <= ev[i];
                if (abort[i]) begin
                    m_armed[i] <= 0;
                    m_left[i]  <= 0;
                    m_done[i]  <= 0;
                end else if (m_done[i]) begin
                    m_done[i]  <= 0;
                    m_armed[i] <= repeat_en[i];
                end else if (m_left[i] > 0) begin
                    if (step_ready[i]) begin
                        m_left[i] <= m_left[i] - 1;
                        if (m_left[i] == 1) m_done[i] <= 1;
                    end
                end else if (m_armed[i]) begin
                    if (q) begin
                        m_armed[i] <= 0;
                        m_left[i]  <= (c == 0) ? 1 : c;
                    end
                end else if (arm[i]) begin
                    m_armed[i] <= 1;
                end
                if ((m_left[i] > 0 || m_done[i]) && q) m_ovr[i] <= 1;
                else if (clr_ovr[i]) m_ovr[i] <= 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : compare
        logic [NCH-1:0] e_sv, e_dn, e_bs, e_ov;
        if (check_en) begin
            for (int i = 0; i < NCH; i++) begin
                e_sv[i] = m_left[i] > 0;
                e_dn[i] = m_done[i];
                e_bs[i] = m_armed[i] || m_left[i] > 0 || m_done[i];
                e_ov[i] = m_ovr[i];
            end
            checkOutput("model_step_valid", 32'(step_valid), 32'(e_sv));
            checkOutput("model_done",       32'(done),       32'(e_dn));
            checkOutput("model_busy",       32'(busy),       32'(e_bs));
            checkOutput("model_overrun",    32'(overrun),    32'(e_ov));
        end
    end

    int nsv [NCH];
    int ndn [NCH];
    int nb3;
    int cyc;

    initial begin
        rst_n = 0; ev = '0; edge_mode = '0; repeat_en = '0; count = '0;
        arm = '0; abort = '0; step_ready = '1; clr_ovr = '0;
        applyStimulus(3);
        check_en = 1;
        checkOutput("reset_busy", 32'(busy), 0);
        rst_n = 1;
        applyStimulus(1);
        checkOutput("post_reset_outputs", 32'({step_valid, done, busy, overrun}), 0);

        $display("[TB] basic loop");
        count[0 +: 8] = 8'd3;
        arm[0] = 1;
        applyStimulus(1);
        arm[0] = 0;
        checkOutput("arm_busy", 32'(busy[0]), 1);
        checkOutput("armed_no_valid", 32'(step_valid[0]), 0);
        ev[0] = 1;
        applyStimulus(1);
        ev[0] = 0;
        checkOutput("basic_sv1", 32'(step_valid[0]), 1);
        applyStimulus(1);
        checkOutput("basic_sv2", 32'(step_valid[0]), 1);
        applyStimulus(1);
        checkOutput("basic_sv3", 32'(step_valid[0]), 1);
        applyStimulus(1);
        checkOutput("basic_done", 32'({step_valid[0], done[0]}), 32'b01);
        applyStimulus(1);
        checkOutput("basic_idle", 32'({done[0], busy[0]}), 0);

        $display("[TB] do-while with backpressure");
        count[0 +: 8] = 8'd0;
        arm[0] = 1;
        applyStimulus(1);
        arm[0] = 0;
        ev[0] = 1;
        applyStimulus(1);
        ev[0] = 0;
        step_ready[0] = 0;
        for (int k = 0; k < 4; k++) begin
            checkOutput("bp_held", 32'(step_valid[0]), 1);
            applyStimulus(1);
        end
        step_ready[0] = 1;
        checkOutput("bp_fifth", 32'(step_valid[0]), 1);
        applyStimulus(1);
        checkOutput("bp_done", 32'({step_valid[0], done[0]}), 32'b01);
        applyStimulus(1);
        checkOutput("bp_idle", 32'({done[0], busy[0]}), 0);

        $display("[TB] forever mode and overrun");
        count[8 +: 8] = 8'd2;
        repeat_en[1] = 1;
        arm[1] = 1;
        applyStimulus(1);
        arm[1] = 0;
        for (int j = 0; j < 12; j++) begin
            ev[1] = (j % 2 == 0);
            clr_ovr[1] = (j == 6 || j == 7);
            applyStimulus(1);
            if (j == 0) checkOutput("fv_first_run", 32'(step_valid[1]), 1);
            if (j == 2) checkOutput("fv_ovr_set", 32'(overrun[1]), 1);
            if (j == 3) checkOutput("fv_rearmed", 32'({busy[1], step_valid[1]}), 32'b10);
            if (j == 4) checkOutput("fv_retrigger", 32'(step_valid[1]), 1);
            if (j == 6) checkOutput("fv_set_beats_clr", 32'(overrun[1]), 1);
            if (j == 7) checkOutput("fv_clr", 32'(overrun[1]), 0);
        end
        ev[1] = 0; repeat_en[1] = 0; abort[1] = 1; clr_ovr[1] = 1;
        applyStimulus(1);
        abort[1] = 0;
        applyStimulus(1);
        clr_ovr[1] = 0;
        checkOutput("fv_cleanup", 32'({busy[1], overrun[1]}), 0);

        $display("[TB] edge modes");
        count = {8'd1, 8'd1, 8'd1, 8'd1};
        edge_mode = {2'b11, 2'b10, 2'b01, 2'b00};
        repeat_en = 4'b1000;
        arm = '1;
        applyStimulus(1);
        arm = '0;
        ev = '0;
        applyStimulus(1);
        ev = '1;
        applyStimulus(1);
        checkOutput("em_first", 32'(step_valid), 32'b1101);
        applyStimulus(1);
        ev = '0;
        applyStimulus(1);
        checkOutput("em_fall", 32'(step_valid), 32'b0010);
        ev = '1;
        applyStimulus(1);
        checkOutput("em_level_retrig", 32'(step_valid), 32'b1000);
        applyStimulus(3);
        ev = '0; repeat_en = '0; abort = '1; clr_ovr = '1;
        applyStimulus(1);
        abort = '0;
        applyStimulus(1);
        clr_ovr = '0;
        edge_mode = '0;
        checkOutput("em_cleanup", 32'({busy, overrun}), 0);

        $display("[TB] abort and reset");
        count[16 +: 8] = 8'd5;
        arm[2] = 1;
        applyStimulus(1);
        arm[2] = 0;
        ev[2] = 1;
        applyStimulus(1);
        ev[2] = 0;
        applyStimulus(3);
        checkOutput("ab_running", 32'(step_valid[2]), 1);
        abort[2] = 1;
        applyStimulus(1);
        abort[2] = 0;
        checkOutput("ab_idle", 32'({step_valid[2], done[2], busy[2]}), 0);
        applyStimulus(1);
        checkOutput("ab_no_done", 32'(done[2]), 0);

        count[0 +: 8] = 8'd10;
        arm[0] = 1;
        applyStimulus(1);
        arm[0] = 0;
        ev[0] = 1;
        applyStimulus(1);
        ev[0] = 0;
        applyStimulus(2);
        checkOutput("rst_pre_run", 32'(step_valid[0]), 1);
        rst_n = 0;
        #1;
        checkOutput("rst_async_clear", 32'({step_valid, done, busy, overrun}), 0);
        applyStimulus(2);
        rst_n = 1;
        applyStimulus(1);
        count[0 +: 8] = 8'd1;
        arm[0] = 1;
        applyStimulus(1);
        arm[0] = 0;
        ev[0] = 1;
        applyStimulus(1);
        ev[0] = 0;
        checkOutput("rst_rearm_run", 32'(step_valid[0]), 1);
        applyStimulus(2);
        checkOutput("rst_rearm_idle", 32'(busy[0]), 0);

        $display("[TB] independence");
        count = {8'd255, 8'd7, 8'd4, 8'd1};
        arm = '1;
        applyStimulus(1);
        arm = '0;
        ev = '1;
        applyStimulus(1);
        ev = '0;
        for (int i = 0; i < NCH; i++) begin
            nsv[i] = 0;
            ndn[i] = 0;
        end
        nb3 = 0;
        cyc = 0;
        while (busy != '0 && cyc < 400) begin
            for (int i = 0; i < NCH; i++) begin
                if (step_valid[i]) nsv[i]++;
                if (done[i]) ndn[i]++;
            end
            if (busy[3]) nb3++;
            applyStimulus(1);
            cyc++;
        end
        checkOutput("ind_timeout", 32'(cyc < 400), 1);
        checkOutput("ind_steps0", nsv[0], 1);
        checkOutput("ind_steps1", nsv[1], 4);
        checkOutput("ind_steps2", nsv[2], 7);
        checkOutput("ind_steps3", nsv[3], 255);
        for (int i = 0; i < NCH; i++) checkOutput("ind_done_pulses", ndn[i], 1);
        checkOutput("ind_busy3_cycles", nb3, 256);

        applyStimulus(2);
        check_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
